lsu_dccm_banked_mem: RTL
========================

Name: lsu_dccm_banked_mem

Overview:
- Parametrised, banked DCCM data store for the LSU DC1->DC2 stage.
- Provides one byte-enabled write port and a lo/hi read pair, so a misaligned access is serviced in one cycle.
- Reads have priority over writes. A write that collides with a read on the same bank parks in a one-entry write buffer and drains when that bank is idle.
- A freeze input stalls the pipe and holds read data stable.

Parameters:
NUM_BANKS, 4, number of banks, power of two, >=2; BANK_BITS = log2(NUM_BANKS)
INDEX_BITS, 8, words per bank = 2**INDEX_BITS
DATA_WIDTH, 32, word width in bits, multiple of 8; NBYTES = DATA_WIDTH/8
ADDR_BITS is derived = BANK_BITS+INDEX_BITS (word address; bank = addr[BANK_BITS-1:0], index = addr[ADDR_BITS-1:BANK_BITS])

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
freeze  in  1  pipeline freeze; no reads, writes, drains or accepts while high
wr_valid  in  1  write request
wr_ready  out  1  write accepted this cycle when wr_valid & wr_ready
wr_addr  in  ADDR_BITS  write word address
wr_data  in  DATA_WIDTH  write data
wr_be  in  NBYTES  byte enables
rd_valid  in  1  read request
rd_addr_lo  in  ADDR_BITS  lower word address
rd_addr_hi  in  ADDR_BITS  upper word address (misaligned second word)
rd_data_lo  out  DATA_WIDTH  read data for rd_addr_lo
rd_data_hi  out  DATA_WIDTH  read data for rd_addr_hi
rd_data_valid  out  1  rd_data_* valid
wb_pending  out  1  write buffer occupied

Behaviour:
- Reset (async, rst=1):
  - rd_data_lo, rd_data_hi and rd_data_valid go to 0; the buffer is emptied (wb_pending=0).
  - Array contents are not reset.
- Read issue (cycle N, rd_valid & ~freeze):
  - Banks are read at rd_addr_lo, and at rd_addr_hi when bank(hi)!=bank(lo).
  - If bank(hi)==bank(lo), rd_data_hi = rd_data_lo.
  - Data is registered and visible in N+1 with rd_data_valid=1.
  - N+1 without a read and without freeze: rd_data_valid=0 and data outputs hold.
- Freeze:
  - While freeze=1 all outputs hold their previous values, including rd_data_valid. wr_ready=0, no array write, no drain.
  - On the first unfrozen cycle the pipe resumes; the held read is not re-issued.
- Write acceptance:
  - wr_ready = ~freeze & ~wb_pending.
  - Accepted write, bank not being read this cycle: the enabled bytes are written to the array at the clock edge.
  - Accepted write, bank being read this cycle (lo or hi): address, data and be are captured into the buffer and wb_pending=1 next cycle.
  - wr_be=0 is accepted and produces no array change and no buffer entry.
- Drain:
  - While wb_pending and unfrozen, the buffer writes its enabled bytes the first cycle its bank is not read. wb_pending clears next cycle.
  - Sustained reads to one bank may stall the drain indefinitely; this is intended.
- Ordering and bypass:
  - A read issued in the same cycle as an accepted write to the same word returns pre-write data.
  - A read issued in a later cycle that hits the buffered word (full address match, lo or hi) returns array data with buffered bytes merged per buffered be.
  - A read in the same cycle as a drain to the same word is impossible, because a drain never targets a bank being read.
- Array model: synchronous-read, byte-write RAM per bank. Any contents not yet written read as X in simulation.
- Reset mid-operation: a buffered write is discarded; an in-flight read is discarded (rd_data_valid=0).

Test Plan:
All scenarios use the default parameters (4 banks, 256 words per bank, 32-bit data).
- Write 0x11223344 to addr 0x05, be=0xF; next cycle read lo=0x05 -> cycle+1 rd_data_lo=0x11223344, rd_data_valid=1, wb_pending never 1.
- Read lo=0x06 concurrent with write 0xAABBCCDD to 0x0A (same bank 2) -> read returns old data at 0x06; wb_pending=1 for one cycle; wr_ready=0 that cycle; later read 0x0A = 0xAABBCCDD.
- Prefill 0x0A=0x00000000. Write 0x0A, data 0xFFFFFFFF, be=0x3, concurrently with a read to bank 2. Hold reads on bank 2 and read 0x0A while buffered -> rd_data_lo=0x0000FFFF (bypass merge); after reads stop, wb_pending drops and the array read gives the same value.
- Misaligned read lo=0x07 (bank 3), hi=0x08 (bank 0), prefilled 0x01010101 and 0x02020202 -> next cycle lo=0x01010101, hi=0x02020202. Read lo=0x05, hi=0x09 (both bank 1) -> hi equals lo.
- Issue read, assert freeze for 3 cycles after it, with wr_valid high during freeze -> rd_data_* and rd_data_valid stable for 3 cycles, wr_ready=0, no array change; write accepted on the first unfrozen cycle.
- Put one write in the buffer, assert rst for 1 cycle -> wb_pending=0, rd_data_valid=0, outputs 0; the buffered write never reaches the array.

Source files
------------

// File: rtl/lsu_dccm_banked_mem_if.sv
// Bundles the LSU-side write port, read pair and status of the banked DCCM store.
// Latency: none, wiring only.
// Backpressure: wr_ready from the slave; reads are always accepted unless frozen.
interface lsu_dccm_banked_mem_if #(
    parameter int NUM_BANKS  = 4,
    parameter int INDEX_BITS = 8,
    parameter int DATA_WIDTH = 32
) ();
    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int ADDR_BITS = BANK_BITS + INDEX_BITS;
    localparam int NBYTES    = DATA_WIDTH / 8;

    logic                  freeze;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_BITS-1:0]  wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NBYTES-1:0]     wr_be;
    logic                  rd_valid;
    logic [ADDR_BITS-1:0]  rd_addr_lo;
    logic [ADDR_BITS-1:0]  rd_addr_hi;
    logic [DATA_WIDTH-1:0] rd_data_lo;
    logic [DATA_WIDTH-1:0] rd_data_hi;
    logic                  rd_data_valid;
    logic                  wb_pending;

    modport master (
        output freeze, wr_valid, wr_addr, wr_data, wr_be,
        output rd_valid, rd_addr_lo, rd_addr_hi,
        input  wr_ready, rd_data_lo, rd_data_hi, rd_data_valid, wb_pending
    );

    modport slave (
        input  freeze, wr_valid, wr_addr, wr_data, wr_be,
        input  rd_valid, rd_addr_lo, rd_addr_hi,
        output wr_ready, rd_data_lo, rd_data_hi, rd_data_valid, wb_pending
    );
endinterface

// File: rtl/lsu_dccm_banked_mem.sv
// Banked, byte-writable DCCM store with a lo/hi read pair and a one-entry write buffer.
// Latency: read data registered, valid one cycle after issue; writes land at the accepting edge or later via the buffer.
// Backpressure: wr_ready drops while frozen or while the write buffer holds a bank-conflicted write.
module lsu_dccm_banked_mem #(
    parameter int NUM_BANKS  = 4,
    parameter int INDEX_BITS = 8,
    parameter int DATA_WIDTH = 32
) (
    input logic                  clk,
    input logic                  rst,
    lsu_dccm_banked_mem_if.slave io_bus
);
    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int ADDR_BITS = BANK_BITS + INDEX_BITS;
    localparam int NBYTES    = DATA_WIDTH / 8;
    localparam int DEPTH     = 1 << INDEX_BITS;

    // Overlay the enabled bytes of d onto base.
    function automatic logic [DATA_WIDTH-1:0] f_merge(input logic [DATA_WIDTH-1:0] base,
                                                      input logic [DATA_WIDTH-1:0] d,
                                                      input logic [NBYTES-1:0]     be);
        logic [DATA_WIDTH-1:0] res;
        res = base;
        for (int k = 0; k < NBYTES; k++) begin
            if (be[k]) res[8*k +: 8] = d[8*k +: 8];
        end
        return res;
    endfunction

    // Write buffer state
    logic                  r_wb_vld;
    logic [ADDR_BITS-1:0]  r_wb_addr;
    logic [DATA_WIDTH-1:0] r_wb_dat;
    logic [NBYTES-1:0]     r_wb_be;

    // Registered read outputs
    logic [DATA_WIDTH-1:0] r_rd_lo;
    logic [DATA_WIDTH-1:0] r_rd_hi;
    logic                  r_rd_vld;

    logic                  w_rd_go;
    logic [BANK_BITS-1:0]  w_bank_lo, w_bank_hi, w_wr_bank, w_wb_bank;
    logic [INDEX_BITS-1:0] w_idx_lo, w_idx_hi;
    logic                  w_wr_ready, w_wr_acc, w_wr_conf, w_wr_direct, w_drain;
    logic                  w_mem_we;
    logic [BANK_BITS-1:0]  w_mem_bank;
    logic [INDEX_BITS-1:0] w_mem_idx;
    logic [DATA_WIDTH-1:0] w_mem_dat;
    logic [NBYTES-1:0]     w_mem_be;
    logic [DATA_WIDTH-1:0] w_bank_dat [NUM_BANKS];
    logic [DATA_WIDTH-1:0] w_rd_lo, w_rd_hi;

    assign w_rd_go   = io_bus.rd_valid & ~io_bus.freeze;
    assign w_bank_lo = io_bus.rd_addr_lo[BANK_BITS-1:0];
    assign w_bank_hi = io_bus.rd_addr_hi[BANK_BITS-1:0];
    assign w_idx_lo  = io_bus.rd_addr_lo[ADDR_BITS-1:BANK_BITS];
    assign w_idx_hi  = io_bus.rd_addr_hi[ADDR_BITS-1:BANK_BITS];
    assign w_wr_bank = io_bus.wr_addr[BANK_BITS-1:0];
    assign w_wb_bank = r_wb_addr[BANK_BITS-1:0];

    // A write with no enabled bytes is accepted but has nothing to do.
    assign w_wr_ready  = ~io_bus.freeze & ~r_wb_vld;
    assign w_wr_acc    = io_bus.wr_valid & w_wr_ready & (|io_bus.wr_be);
    assign w_wr_conf   = w_wr_acc & w_rd_go &
                         ((w_wr_bank == w_bank_lo) | (w_wr_bank == w_bank_hi));
    assign w_wr_direct = w_wr_acc & ~w_wr_conf;
    // Drain only into a bank the reads leave idle; reads win every collision.
    assign w_drain     = r_wb_vld & ~io_bus.freeze &
                         ~(w_rd_go & ((w_wb_bank == w_bank_lo) | (w_wb_bank == w_bank_hi)));

    // Direct write and drain never coincide: accepting needs an empty buffer.
    assign w_mem_we   = w_wr_direct | w_drain;
    assign w_mem_bank = w_drain ? w_wb_bank : w_wr_bank;
    assign w_mem_idx  = w_drain ? r_wb_addr[ADDR_BITS-1:BANK_BITS]
                                : io_bus.wr_addr[ADDR_BITS-1:BANK_BITS];
    assign w_mem_dat  = w_drain ? r_wb_dat : io_bus.wr_data;
    assign w_mem_be   = w_drain ? r_wb_be : io_bus.wr_be;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] r_mem [DEPTH];
        logic [INDEX_BITS-1:0] w_rd_idx;

        // Each bank has one read port; it serves lo when lo targets it, else hi.
        assign w_rd_idx      = (w_bank_lo == BANK_BITS'(b)) ? w_idx_lo : w_idx_hi;
        assign w_bank_dat[b] = r_mem[w_rd_idx];

        // Byte-enabled array write; contents are deliberately not reset.
        always_ff @(posedge clk) begin
            if (w_mem_we && (w_mem_bank == BANK_BITS'(b))) begin
                for (int k = 0; k < NBYTES; k++) begin
                    if (w_mem_be[k]) r_mem[w_mem_idx][8*k +: 8] <= w_mem_dat[8*k +: 8];
                end
            end
        end
    end

    // Read data with bypass of any buffered bytes for the same word.
    always_comb begin
        w_rd_lo = w_bank_dat[w_bank_lo];
        if (r_wb_vld && (r_wb_addr == io_bus.rd_addr_lo))
            w_rd_lo = f_merge(w_bank_dat[w_bank_lo], r_wb_dat, r_wb_be);
        w_rd_hi = w_bank_dat[w_bank_hi];
        if (r_wb_vld && (r_wb_addr == io_bus.rd_addr_hi))
            w_rd_hi = f_merge(w_bank_dat[w_bank_hi], r_wb_dat, r_wb_be);
        if (w_bank_hi == w_bank_lo)
            w_rd_hi = w_rd_lo;
    end

    // Write buffer: capture bank-conflicted writes, release on drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_vld  <= 1'b0;
            r_wb_addr <= '0;
            r_wb_dat  <= '0;
            r_wb_be   <= '0;
        end else if (w_drain) begin
            r_wb_vld <= 1'b0;
        end else if (w_wr_conf) begin
            r_wb_vld  <= 1'b1;
            r_wb_addr <= io_bus.wr_addr;
            r_wb_dat  <= io_bus.wr_data;
            r_wb_be   <= io_bus.wr_be;
        end
    end

    // Read output stage: load on issue, drop valid when idle, hold everything when frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_lo  <= '0;
            r_rd_hi  <= '0;
            r_rd_vld <= 1'b0;
        end else if (!io_bus.freeze) begin
            r_rd_vld <= io_bus.rd_valid;
            if (io_bus.rd_valid) begin
                r_rd_lo <= w_rd_lo;
                r_rd_hi <= w_rd_hi;
            end
        end
    end

    assign io_bus.wr_ready      = w_wr_ready;
    assign io_bus.rd_data_lo    = r_rd_lo;
    assign io_bus.rd_data_hi    = r_rd_hi;
    assign io_bus.rd_data_valid = r_rd_vld;
    assign io_bus.wb_pending    = r_wb_vld;
endmodule
